// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: receiving-end model of the 4-bit HD44780 character-LCD bus.
// Decodes EN strobes into init nibbles or assembled bytes, and flags
// short strobes, strobes during the busy window, and read strobes.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   LCD_RS, LCD_RW        register select / read-write from the controller
//   LCD_EN, LCD_SF_D      enable strobe and data nibble
//   init_valid, init_nibble   standalone nibble accepted in init mode
//   rx_valid, rx_data, rx_rs  byte assembled in 4-bit mode
//   rx_count              bytes received since reset (wraps)
//   mode_4bit             0 = init mode, 1 = 4-bit pairing mode
//   err_short_en, err_busy, err_rw   one-cycle violation pulses
module lcd_bus_receiver #(
    parameter int EN_MIN_CYCLES = 12,
    parameter int GAP_CYCLES    = 50,
    parameter int CMD_WAIT      = 2000,
    parameter int CLEAR_WAIT    = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [3:0] LCD_SF_D,
    output logic       init_valid,
    output logic [3:0] init_nibble,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_rs,
    output logic [7:0] rx_count,
    output logic       mode_4bit,
    output logic       err_short_en,
    output logic       err_busy,
    output logic       err_rw
);

    localparam int HW = $clog2(EN_MIN_CYCLES + 1);

    typedef enum logic {
        PH_HIGH,
        PH_LOW
    } phase_t;

    phase_t      phase, phase_nx;
    logic        en_q, rs_q, rw_q;
    logic [3:0]  d_q;
    logic [HW-1:0] hi_cnt;
    logic        ignored;
    logic [16:0] busy_cnt, busy_nx;
    logic [3:0]  stored, stored_nx;
    logic        mode_nx;
    logic        init_v_nx, rx_v_nx, short_nx, busy_err_nx, rw_err_nx;
    logic [3:0]  nib_nx;
    logic [7:0]  data_nx, cnt_nx, byte_val;
    logic        rs_nx;
    logic        rise, fall, hi_ok, accept;

    assign rise     = LCD_EN & ~en_q;
    assign fall     = ~LCD_EN & en_q;
    assign hi_ok    = hi_cnt >= HW'(EN_MIN_CYCLES);
    assign accept   = fall & ~ignored & hi_ok;
    assign byte_val = {stored, d_q};

    always_comb begin
        phase_nx    = phase;
        mode_nx     = mode_4bit;
        stored_nx   = stored;
        busy_nx     = (busy_cnt == 17'd0) ? 17'd0 : busy_cnt - 17'd1;
        init_v_nx   = 1'b0;
        nib_nx      = init_nibble;
        rx_v_nx     = 1'b0;
        data_nx     = rx_data;
        rs_nx       = rx_rs;
        cnt_nx      = rx_count;
        short_nx    = fall & ~ignored & ~hi_ok;
        rw_err_nx   = rise & (rw_q | LCD_RW);
        busy_err_nx = rise & mode_4bit & (busy_cnt != 17'd0);
        if (accept) begin
            if (!mode_4bit) begin
                init_v_nx = 1'b1;
                nib_nx    = d_q;
                if (d_q == 4'h2) begin
                    mode_nx  = 1'b1;
                    phase_nx = PH_HIGH;
                end
            end else begin
                unique case (phase)
                    PH_HIGH: begin
                        stored_nx = d_q;
                        phase_nx  = PH_LOW;
                        busy_nx   = 17'(GAP_CYCLES);
                    end
                    PH_LOW: begin
                        rx_v_nx  = 1'b1;
                        data_nx  = byte_val;
                        rs_nx    = rs_q;
                        cnt_nx   = rx_count + 8'd1;
                        phase_nx = PH_HIGH;
                        // clear and home need the long settle time
                        if (!rs_q && (byte_val == 8'h01 || byte_val == 8'h02))
                            busy_nx = 17'(CLEAR_WAIT);
                        else
                            busy_nx = 17'(CMD_WAIT);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= PH_HIGH;
            en_q         <= 1'b0;
            rs_q         <= 1'b0;
            rw_q         <= 1'b0;
            d_q          <= 4'h0;
            hi_cnt       <= '0;
            ignored      <= 1'b0;
            busy_cnt     <= 17'd0;
            stored       <= 4'h0;
            mode_4bit    <= 1'b0;
            init_valid   <= 1'b0;
            init_nibble  <= 4'h0;
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_rs        <= 1'b0;
            rx_count     <= 8'h00;
            err_short_en <= 1'b0;
            err_busy     <= 1'b0;
            err_rw       <= 1'b0;
        end else begin
            en_q <= LCD_EN;
            rs_q <= LCD_RS;
            rw_q <= LCD_RW;
            d_q  <= LCD_SF_D;
            // the rise edge itself is the first high sample
            if (rise)
                hi_cnt <= HW'(1);
            else if (LCD_EN && !hi_ok)
                hi_cnt <= hi_cnt + HW'(1);
            if (rise)
                ignored <= rw_q | LCD_RW;
            phase        <= phase_nx;
            busy_cnt     <= busy_nx;
            stored       <= stored_nx;
            mode_4bit    <= mode_nx;
            init_valid   <= init_v_nx;
            init_nibble  <= nib_nx;
            rx_valid     <= rx_v_nx;
            rx_data      <= data_nx;
            rx_rs        <= rs_nx;
            rx_count     <= cnt_nx;
            err_short_en <= short_nx;
            err_busy     <= busy_err_nx;
            err_rw       <= rw_err_nx;
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: directed table plus randomized strobes for
// lcd_bus_receiver, checked against a strobe-level reference model.
module tb_lcd_bus_receiver;

    localparam int EN_MIN = 12;
    localparam int GAP    = 50;
    localparam int CMD    = 2000;
    // shortened clear wait keeps the run well inside the cycle budget
    localparam int CLEAR  = 8200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic       LCD_EN = 1'b0;
    logic [3:0] LCD_SF_D = 4'h0;
    logic       init_valid;
    logic [3:0] init_nibble;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic [7:0] rx_count;
    logic       mode_4bit;
    logic       err_short_en;
    logic       err_busy;
    logic       err_rw;

    lcd_bus_receiver #(
        .EN_MIN_CYCLES(EN_MIN),
        .GAP_CYCLES(GAP),
        .CMD_WAIT(CMD),
        .CLEAR_WAIT(CLEAR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN),
        .LCD_SF_D(LCD_SF_D),
        .init_valid(init_valid),
        .init_nibble(init_nibble),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_rs(rx_rs),
        .rx_count(rx_count),
        .mode_4bit(mode_4bit),
        .err_short_en(err_short_en),
        .err_busy(err_busy),
        .err_rw(err_rw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic       busy;
        logic       iv;
        logic [3:0] nib;
        logic       rv;
        logic [7:0] data;
        logic       rs;
        logic       sh;
        logic       mode;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [3:0] d;
        int         hi;
        int         lo;
        obs_t       exp;
    } vec_t;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_iv = 0, n_rv = 0, n_sh = 0, n_bz = 0, n_rw = 0;
    int e_iv = 0, e_rv = 0, e_sh = 0, e_bz = 0, e_rw = 0;

    // reference model state
    logic       m_mode;
    logic       m_high;
    logic [3:0] m_stored;
    logic [7:0] m_cnt;
    int         m_free;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (init_valid)   n_iv <= n_iv + 1;
            if (rx_valid)     n_rv <= n_rv + 1;
            if (err_short_en) n_sh <= n_sh + 1;
            if (err_busy)     n_bz <= n_bz + 1;
            if (err_rw)       n_rw <= n_rw + 1;
        end
    end

    function automatic obs_t mk(logic rw, logic busy, logic iv,
                                logic [3:0] nib, logic rv,
                                logic [7:0] data, logic rs, logic sh,
                                logic mode, logic [7:0] cnt);
        obs_t o;
        o = '{rw, busy, iv, nib, rv, data, rs, sh, mode, cnt};
        return o;
    endfunction

    task automatic model_reset();
        m_mode   = 1'b0;
        m_high   = 1'b1;
        m_stored = 4'h0;
        m_cnt    = 8'h00;
        m_free   = 0;
    endtask

    // Strobe-level model: busy windows as absolute edge numbers.
    task automatic model_step(input logic rs, input logic rw,
                              input logic [3:0] d, input int hi,
                              input int r, input int f,
                              output obs_t e);
        logic [7:0] b;
        e      = '0;
        e.rw   = rw;
        e.busy = m_mode && (r < m_free);
        if (!rw) begin
            if (hi < EN_MIN) begin
                e.sh = 1'b1;
            end else if (!m_mode) begin
                e.iv  = 1'b1;
                e.nib = d;
                if (d == 4'h2) begin
                    m_mode = 1'b1;
                    m_high = 1'b1;
                end
            end else if (m_high) begin
                m_stored = d;
                m_high   = 1'b0;
                m_free   = f + GAP + 1;
            end else begin
                b      = {m_stored, d};
                e.rv   = 1'b1;
                e.data = b;
                e.rs   = rs;
                m_cnt  = m_cnt + 8'd1;
                m_high = 1'b1;
                if (!rs && (b == 8'h01 || b == 8'h02))
                    m_free = f + CLEAR + 1;
                else
                    m_free = f + CMD + 1;
            end
        end
        e.mode = m_mode;
        e.cnt  = m_cnt;
        e_iv += int'(e.iv);
        e_rv += int'(e.rv);
        e_sh += int'(e.sh);
        e_bz += int'(e.busy);
        e_rw += int'(e.rw);
    endtask

    // Called at a negedge; EN high for hi edges, then lo idle edges
    // strictly between the fall edge and the next rise edge.
    task automatic strobe(input logic rs, input logic rw,
                          input logic [3:0] d, input int hi, input int lo,
                          output obs_t o, output int r, output int f);
        o        = '0;
        LCD_EN   = 1'b1;
        LCD_RS   = rs;
        LCD_RW   = rw;
        LCD_SF_D = d;
        @(negedge clk);
        r      = cyc;
        o.rw   = err_rw;
        o.busy = err_busy;
        repeat (hi - 1) @(negedge clk);
        LCD_EN = 1'b0;
        LCD_RW = 1'b0;
        @(negedge clk);
        f      = cyc;
        o.iv   = init_valid;
        o.nib  = init_nibble;
        o.rv   = rx_valid;
        o.data = rx_data;
        o.rs   = rx_rs;
        o.sh   = err_short_en;
        o.mode = mode_4bit;
        o.cnt  = rx_count;
        LCD_SF_D = 4'($urandom);
        LCD_RS   = 1'($urandom);
        repeat (lo) @(negedge clk);
    endtask

    task automatic apply(input logic rs, input logic rw,
                         input logic [3:0] d, input int hi, input int lo,
                         output obs_t got, output obs_t mdl);
        int r, f;
        strobe(rs, rw, d, hi, lo, got, r, f);
        model_step(rs, rw, d, hi, r, f, mdl);
    endtask

    task automatic check_obs(input string name, input obs_t g, input obs_t e);
        logic ok;
        checks++;
        ok = (g.rw == e.rw) && (g.busy == e.busy) && (g.iv == e.iv) &&
             (g.rv == e.rv) && (g.sh == e.sh) && (g.mode == e.mode) &&
             (g.cnt == e.cnt);
        if (e.iv && g.nib != e.nib) ok = 1'b0;
        if (e.rv && (g.data != e.data || g.rs != e.rs)) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got rw=%b busy=%b iv=%b nib=%h rv=%b data=%h rs=%b sh=%b mode=%b cnt=%0d, expected rw=%b busy=%b iv=%b nib=%h rv=%b data=%h rs=%b sh=%b mode=%b cnt=%0d",
                     name, g.rw, g.busy, g.iv, g.nib, g.rv, g.data, g.rs,
                     g.sh, g.mode, g.cnt, e.rw, e.busy, e.iv, e.nib, e.rv,
                     e.data, e.rs, e.sh, e.mode, e.cnt);
        end
    endtask

    task automatic check_int(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        logic [31:0] all;
        all = {init_valid, init_nibble, rx_valid, rx_data, rx_rs, rx_count,
               mode_4bit, err_short_en, err_busy, err_rw};
        checks++;
        if (all != 32'h0) begin
            errors++;
            $display("FAIL %s: got outputs %h expected 0", name, all);
        end
    endtask

    vec_t tbl[19];

    initial begin
        obs_t got, mdl;
        tbl[0]  = '{1'b0, 1'b0, 4'h3, 12, 288, mk(0,0,1,4'h3,0,8'h00,0,0,0,8'd0)};
        tbl[1]  = '{1'b0, 1'b0, 4'h3, 12, 288, mk(0,0,1,4'h3,0,8'h00,0,0,0,8'd0)};
        tbl[2]  = '{1'b0, 1'b0, 4'h3, 12, 288, mk(0,0,1,4'h3,0,8'h00,0,0,0,8'd0)};
        tbl[3]  = '{1'b0, 1'b0, 4'h2, 12, 288, mk(0,0,1,4'h2,0,8'h00,0,0,1,8'd0)};
        tbl[4]  = '{1'b0, 1'b0, 4'h2, 12, 50,  mk(0,0,0,4'h0,0,8'h00,0,0,1,8'd0)};
        tbl[5]  = '{1'b0, 1'b0, 4'h8, 12, 2000, mk(0,0,0,4'h0,1,8'h28,0,0,1,8'd1)};
        tbl[6]  = '{1'b1, 1'b0, 4'h4, 12, 50,  mk(0,0,0,4'h0,0,8'h00,0,0,1,8'd1)};
        tbl[7]  = '{1'b1, 1'b0, 4'h1, 12, 1999, mk(0,0,0,4'h0,1,8'h41,1,0,1,8'd2)};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 12, 50,  mk(0,1,0,4'h0,0,8'h00,0,0,1,8'd2)};
        tbl[9]  = '{1'b0, 1'b0, 4'h1, 12, 2000, mk(0,0,0,4'h0,1,8'h01,0,0,1,8'd3)};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 12, 50,  mk(0,1,0,4'h0,0,8'h00,0,0,1,8'd3)};
        tbl[11] = '{1'b0, 1'b0, 4'h1, 12, CLEAR, mk(0,0,0,4'h0,1,8'h01,0,0,1,8'd4)};
        tbl[12] = '{1'b1, 1'b0, 4'h4, 12, 50,  mk(0,0,0,4'h0,0,8'h00,0,0,1,8'd4)};
        tbl[13] = '{1'b1, 1'b0, 4'h5, 11, 50,  mk(0,0,0,4'h0,0,8'h00,0,1,1,8'd4)};
        tbl[14] = '{1'b1, 1'b0, 4'h5, 12, 2000, mk(0,0,0,4'h0,1,8'h45,1,0,1,8'd5)};
        tbl[15] = '{1'b0, 1'b1, 4'h7, 12, 50,  mk(1,0,0,4'h0,0,8'h00,0,0,1,8'd5)};
        tbl[16] = '{1'b1, 1'b0, 4'h6, 12, 50,  mk(0,0,0,4'h0,0,8'h00,0,0,1,8'd5)};
        tbl[17] = '{1'b1, 1'b0, 4'h1, 12, 2000, mk(0,0,0,4'h0,1,8'h61,1,0,1,8'd6)};
        tbl[18] = '{1'b0, 1'b0, 4'h3, 12, 10,  mk(0,0,0,4'h0,0,8'h00,0,0,1,8'd6)};

        model_reset();
        repeat (10) @(negedge clk);
        check_zero_outputs("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].rs, tbl[i].rw, tbl[i].d, tbl[i].hi, tbl[i].lo,
                  got, mdl);
            check_obs($sformatf("row%0d", i), got, tbl[i].exp);
        end

        // reset after a lone high nibble
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_mid_byte");
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_zero_outputs("after_reset_release");

        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, (i == 3) ? 4'h2 : 4'h3, 12, 20, got, mdl);
            check_obs($sformatf("reinit%0d", i), got, mdl);
        end

        for (int i = 0; i < 512; i++) begin
            apply(1'($urandom), 1'b0, 4'($urandom), 12,
                  $urandom_range(0, 60), got, mdl);
            check_obs($sformatf("wrap%0d", i), got, mdl);
        end
        check_int("rx_count_wrap", int'(rx_count), 0);

        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom),
                  $urandom_range(9, 14), $urandom_range(0, 70), got, mdl);
            check_obs($sformatf("rand%0d", i), got, mdl);
        end

        repeat (5) @(negedge clk);
        check_int("count_init_valid", n_iv, e_iv);
        check_int("count_rx_valid", n_rv, e_rv);
        check_int("count_err_short_en", n_sh, e_sh);
        check_int("count_err_busy", n_bz, e_bz);
        check_int("count_err_rw", n_rw, e_rw);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
